alsu_multi_shift_ctrl: RTL and testbench
========================================

Name: alsu_multi_shift_ctrl

Overview:
- Iterative shift-amount controller that sits directly upstream of, and in a loop with, the ALSU's single-step arithmetic shifter stage.
- Accepts one operand (A or B), a shift selector and a shift amount, then drives the 1-bit shifter once per clock, feeding its output back, until the amount is exhausted.
- Returns the multi-bit shift result to the ALSU output mux through a valid/ready handshake.

Parameters:
- WIDTH, 4, operand and result width
- SEL_WIDTH, 2, shift selector width
- CNT_WIDTH, 3, shift-amount width; amounts 0..2^CNT_WIDTH-1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  request present
- start_ready  output  1  controller can accept a request
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_sel  input  SEL_WIDTH  00 shift-right A, 01 shift-left A, 10 shift-right B, 11 shift-left B
- shamt  input  CNT_WIDTH  number of single-bit shifts
- sh_a  output  WIDTH  A operand driven to the single-step shifter
- sh_b  output  WIDTH  B operand driven to the single-step shifter
- sh_sel  output  SEL_WIDTH  selector driven to the single-step shifter
- sh_out  input  WIDTH  single-step shifter result (combinational return)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  shifted result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - FSM goes to IDLE.
  - work register = 0; count = 0; latched selector = 0.
  - res_valid = 0; start_ready = 1 (once IDLE).
  - sh_a, sh_b, sh_sel = 0; busy = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid: latch op_sel; work = op_sel[1] ? op_b : op_a; count = min(shamt, WIDTH).
  - If the effective count is 0, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - Operand drive: when sel[1] = 0, sh_a = work and sh_b = 0. When sel[1] = 1, sh_b = work and sh_a = 0.
  - sh_sel = latched selector.
  - Each clock: work <= sh_out; count <= count - 1.
  - When count = 1 at the clock edge, go to DONE.
- DONE:
  - res_valid = 1; res_data = work.
  - When res_valid && res_ready, go to IDLE.
  - res_data is held stable while res_ready is low.
- Outside SHIFT, sh_a, sh_b and sh_sel are driven to 0.
- Latency:
  - From request accept to res_valid = effective count + 1 cycles.
  - shamt = 0 gives res_valid the cycle after accept.
- Clamping:
  - shamt >= WIDTH is clamped to WIDTH iterations.
  - The single-step shifter zero-fills in both directions, so the result is all zeros.
- start_ready = 0 in SHIFT and DONE; start_valid is ignored there.
- A DONE handshake and a new start_valid in the same cycle are not accepted together. The new request is accepted in the following IDLE cycle.
- Reset asserted mid-SHIFT or mid-DONE:
  - Immediate return to IDLE with all reset values.
  - The in-flight result is discarded and no res_valid is produced.
- sh_out is sampled only in SHIFT; X on sh_out in other states has no effect.

Optional Feature:
- Macro: ALSU_SHIFT_STICKY_EN.
- When defined:
  - Adds output res_sticky (1 bit), valid with res_valid.
  - res_sticky is the OR of every bit shifted out across all iterations.
  - Right shifts contribute work[0]; left shifts contribute work[WIDTH-1], sampled each SHIFT cycle.
  - Cleared on accept and on reset.
- When undefined: the port and the logic are absent; all other behaviour is identical.

Decomposition:
- Package alsu_shift_pkg holds:
  - selector localparams SEL_SHR_A = 2'b00, SEL_SHL_A = 2'b01, SEL_SHR_B = 2'b10, SEL_SHL_B = 2'b11;
  - the FSM state enum (IDLE, SHIFT, DONE);
  - a WIDTH-derived clamp constant.
- One sub-module: alsu_shift_counter.
  - Loadable down-counter with clamp-on-load and an is_one/is_zero flag.
  - Instantiated once inside alsu_multi_shift_ctrl.
- The bench instantiates the existing single-step shifter and closes the loop: sh_a/sh_b/sh_sel feed the shifter, and the shifter output feeds sh_out.

Test Plan:
- op_a = 1100, op_sel = 00, shamt = 2 -> two SHIFT cycles, then res_valid with res_data = 0011, 3 cycles after accept.
- op_b = 0101, op_sel = 11, shamt = 1 -> res_data = 1010; sh_a = 0000 and sh_sel = 11 during SHIFT.
- op_a = 1011, op_sel = 01, shamt = 0 -> res_valid on the next cycle, res_data = 1011; sh_a/sh_b/sh_sel never leave 0.
- op_b = 1111, op_sel = 10, shamt = 6 -> exactly 4 SHIFT cycles, res_data = 0000.
- Backpressure:
  - op_a = 0011, op_sel = 01, shamt = 1, res_ready low for 5 cycles -> res_data = 0110 held, start_ready = 0 throughout.
  - A second request offered during the stall is accepted only after the handshake.
- Reset mid-SHIFT:
  - op_a = 1000, op_sel = 01, shamt = 3, rst_n pulsed low between clock edges during the 2nd SHIFT cycle.
  - Required: busy = 0, res_valid = 0, sh_* = 0 immediately.
  - Required: the next request, op_a = 0001, op_sel = 01, shamt = 2, yields 0100.
  - With ALSU_SHIFT_STICKY_EN: op_a = 0101, op_sel = 00, shamt = 2 -> res_data = 0001, res_sticky = 1.

Source files
------------

// File: rtl/alsu_shift_pkg.sv
// Shared types and constants for the ALSU iterative shift controller.
// Selector encodings, FSM state enum and shift-count clamp constants.
package alsu_shift_pkg;

  localparam logic [1:0] SEL_SHR_A = 2'b00;
  localparam logic [1:0] SEL_SHL_A = 2'b01;
  localparam logic [1:0] SEL_SHR_B = 2'b10;
  localparam logic [1:0] SEL_SHL_B = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int unsigned ALSU_WIDTH  = 4;
  localparam int unsigned SHIFT_CLAMP = ALSU_WIDTH;

  // Counter must hold both the raw amount and the clamp value.
  function automatic int unsigned cnt_bits(
    input int unsigned width,
    input int unsigned cnt_width
  );
    int unsigned need;
    need = $clog2(width + 1);
    return (need > cnt_width) ? need : cnt_width;
  endfunction

endpackage

// File: rtl/alsu_shift_counter.sv
// Loadable down-counter with clamp-on-load.
// Flags count==1 / count==0 and a zero load amount.
module alsu_shift_counter
  import alsu_shift_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 3,
  parameter int unsigned CW        = 3,
  parameter int unsigned MAX       = SHIFT_CLAMP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 is_one,
  output logic                 is_zero,
  output logic                 load_zero
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] load_ext;

  always_comb begin
    load_ext = CW'(load_val);
    cnt_d    = cnt_q;
    if (load) begin
      cnt_d = (load_ext > MAX_C) ? MAX_C : load_ext;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one    = (cnt_q == CW'(1));
  assign is_zero   = (cnt_q == '0);
  assign load_zero = (load_val == '0);

endmodule

// File: rtl/alsu_multi_shift_ctrl.sv
// Iterative multi-bit shift controller looping a 1-bit ALSU shifter.
// Optional sticky (shifted-out OR) output under ALSU_SHIFT_STICKY_EN.
module alsu_multi_shift_ctrl
  import alsu_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = ALSU_WIDTH,
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [SEL_WIDTH-1:0] op_sel,
  input  logic [CNT_WIDTH-1:0] shamt,
  output logic [WIDTH-1:0]     sh_a,
  output logic [WIDTH-1:0]     sh_b,
  output logic [SEL_WIDTH-1:0] sh_sel,
  input  logic [WIDTH-1:0]     sh_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
`ifdef ALSU_SHIFT_STICKY_EN
  output logic                 res_sticky,
`endif
  output logic                 busy
);

  localparam int unsigned CW = cnt_bits(WIDTH, CNT_WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_is_one;
  logic                 cnt_is_zero;
  logic                 cnt_load_zero;
`ifdef ALSU_SHIFT_STICKY_EN
  logic                 sticky_q, sticky_d;
`endif

  alsu_shift_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .CW        (CW),
    .MAX       (WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_val  (shamt),
    .dec       (cnt_dec),
    .is_one    (cnt_is_one),
    .is_zero   (cnt_is_zero),
    .load_zero (cnt_load_zero)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    sel_d       = sel_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    sh_a        = '0;
    sh_b        = '0;
    sh_sel      = '0;
    busy        = 1'b0;
`ifdef ALSU_SHIFT_STICKY_EN
    sticky_d    = sticky_q;
`endif
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          sel_d    = op_sel;
          work_d   = op_sel[1] ? op_b : op_a;
          cnt_load = 1'b1;
          state_d  = cnt_load_zero ? DONE : SHIFT;
`ifdef ALSU_SHIFT_STICKY_EN
          sticky_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        sh_sel  = sel_q;
        if (sel_q[1]) begin
          sh_b = work_q;
        end else begin
          sh_a = work_q;
        end
        work_d  = sh_out;
        cnt_dec = 1'b1;
`ifdef ALSU_SHIFT_STICKY_EN
        // sel[0] set means left shift: the MSB falls off
        sticky_d = sticky_q |
          (sel_q[0] ? work_q[WIDTH-1] : work_q[0]);
`endif
        if (cnt_is_one || cnt_is_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      sel_q    <= '0;
`ifdef ALSU_SHIFT_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      sel_q    <= sel_d;
`ifdef ALSU_SHIFT_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign res_data = work_q;
`ifdef ALSU_SHIFT_STICKY_EN
  assign res_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alsu_multi_shift_ctrl.sv
// Directed bench for alsu_multi_shift_ctrl with a modelled 1-bit shifter.
// Sticky checks compile in when ALSU_SHIFT_STICKY_EN is defined.
module tb_alsu_multi_shift_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [1:0] op_sel;
  logic [2:0] shamt;
  logic [3:0] sh_a;
  logic [3:0] sh_b;
  logic [1:0] sh_sel;
  logic [3:0] sh_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       busy;
`ifdef ALSU_SHIFT_STICKY_EN
  logic       res_sticky;
`endif

  int errors = 0;
  int checks = 0;

  alsu_multi_shift_ctrl #(
    .WIDTH     (4),
    .SEL_WIDTH (2),
    .CNT_WIDTH (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_sel      (op_sel),
    .shamt       (shamt),
    .sh_a        (sh_a),
    .sh_b        (sh_b),
    .sh_sel      (sh_sel),
    .sh_out      (sh_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
`ifdef ALSU_SHIFT_STICKY_EN
    .res_sticky  (res_sticky),
`endif
    .busy        (busy)
  );

  // Single-step zero-filling shifter closing the loop
  logic [3:0] step_src;
  always_comb begin
    step_src = sh_sel[1] ? sh_b : sh_a;
    sh_out   = sh_sel[0] ? (step_src << 1) : (step_src >> 1);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic issue(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [1:0] sel,
    input logic [2:0] amt
  );
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    op_sel      = sel;
    shamt       = amt;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_done(
    output int         lat,
    output int         shifts,
    output logic [3:0] fa,
    output logic [3:0] fb,
    output logic [1:0] fsel,
    output logic       any_sh
  );
    lat    = -1;
    shifts = 0;
    fa     = '0;
    fb     = '0;
    fsel   = '0;
    any_sh = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sh_a != 0 || sh_b != 0 || sh_sel != 0) any_sh = 1'b1;
      if (busy && !res_valid) begin
        if (shifts == 0) begin
          fa   = sh_a;
          fb   = sh_b;
          fsel = sh_sel;
        end
        shifts++;
      end
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic ack();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    op_sel      = '0;
    shamt       = '0;
    res_ready   = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got v=%b b=%b want 0 0", res_valid, busy);
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", start_ready);
    end
    checks++;
    if ({sh_a, sh_b, sh_sel} !== 10'b0) begin
      errors++;
      $display("FAIL rst_sh: got %b want 0", {sh_a, sh_b, sh_sel});
    end
    checks++;
    if (res_data !== 4'b0000) begin
      errors++;
      $display("FAIL rst_data: got %b want 0000", res_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_shr_a();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    issue(4'b1100, 4'b0000, 2'b00, 3'd2);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 3 || sh !== 2) begin
      errors++;
      $display("FAIL shr_lat: got lat=%0d sh=%0d want 3 2", lat, sh);
    end
    checks++;
    if (res_data !== 4'b0011) begin
      errors++;
      $display("FAIL shr_data: got %b want 0011", res_data);
    end
    checks++;
    if (fa !== 4'b1100 || fb !== 4'b0000 || fs !== 2'b00) begin
      errors++;
      $display("FAIL shr_drive: got %b %b %b want 1100 0000 00", fa, fb, fs);
    end
`ifdef ALSU_SHIFT_STICKY_EN
    checks++;
    if (res_sticky !== 1'b0) begin
      errors++;
      $display("FAIL shr_sticky: got %b want 0", res_sticky);
    end
`endif
    ack();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL shr_ack: got v=%b r=%b want 0 1", res_valid, start_ready);
    end
  endtask

  task automatic test_shl_b();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    issue(4'b0000, 4'b0101, 2'b11, 3'd1);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 2 || sh !== 1) begin
      errors++;
      $display("FAIL shlb_lat: got lat=%0d sh=%0d want 2 1", lat, sh);
    end
    checks++;
    if (res_data !== 4'b1010) begin
      errors++;
      $display("FAIL shlb_data: got %b want 1010", res_data);
    end
    checks++;
    if (fa !== 4'b0000 || fb !== 4'b0101 || fs !== 2'b11) begin
      errors++;
      $display("FAIL shlb_drive: got %b %b %b want 0000 0101 11", fa, fb, fs);
    end
    ack();
  endtask

  task automatic test_zero_amt();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    issue(4'b1011, 4'b0000, 2'b01, 3'd0);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 1 || sh !== 0) begin
      errors++;
      $display("FAIL zero_lat: got lat=%0d sh=%0d want 1 0", lat, sh);
    end
    checks++;
    if (res_data !== 4'b1011) begin
      errors++;
      $display("FAIL zero_data: got %b want 1011", res_data);
    end
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL zero_sh: got active=%b want 0", any);
    end
    ack();
  endtask

  task automatic test_clamp();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    issue(4'b0000, 4'b1111, 2'b10, 3'd6);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 5 || sh !== 4) begin
      errors++;
      $display("FAIL clamp_lat: got lat=%0d sh=%0d want 5 4", lat, sh);
    end
    checks++;
    if (res_data !== 4'b0000) begin
      errors++;
      $display("FAIL clamp_data: got %b want 0000", res_data);
    end
    checks++;
    if (fa !== 4'b0000 || fb !== 4'b1111 || fs !== 2'b10) begin
      errors++;
      $display("FAIL clamp_drive: got %b %b %b want 0000 1111 10", fa, fb, fs);
    end
`ifdef ALSU_SHIFT_STICKY_EN
    checks++;
    if (res_sticky !== 1'b1) begin
      errors++;
      $display("FAIL clamp_sticky: got %b want 1", res_sticky);
    end
`endif
    ack();
  endtask

  task automatic test_backpressure();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    int bad;
    res_ready = 1'b0;
    issue(4'b0011, 4'b0000, 2'b01, 3'd1);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL bp_lat: got %0d want 2", lat);
    end
    op_a        = 4'b0010;
    op_b        = 4'b0000;
    op_sel      = 2'b00;
    shamt       = 3'd1;
    start_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== 4'b0110 ||
          start_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    res_ready = 1'b1;
    ack();
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: got r=%b v=%b want 1 0", start_ready, res_valid);
    end
    @(posedge clk);
    #1 start_valid = 1'b0;
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 2 || res_data !== 4'b0001) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d d=%b want 2 0001", lat, res_data);
    end
    ack();
  endtask

  task automatic test_reset_mid_shift();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    int seen;
    issue(4'b1000, 4'b0000, 2'b01, 3'd3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sh_a !== 4'b0000) begin
      errors++;
      $display("FAIL mid_shift2: got b=%b a=%b want 1 0000", busy, sh_a);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_flags: got b=%b v=%b want 0 0", busy, res_valid);
    end
    checks++;
    if ({sh_a, sh_b, sh_sel} !== 10'b0) begin
      errors++;
      $display("FAIL mid_sh: got %b want 0", {sh_a, sh_b, sh_sel});
    end
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_discard: got %0d valid cycles want 0", seen);
    end
    issue(4'b0001, 4'b0000, 2'b01, 3'd2);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (lat !== 3 || res_data !== 4'b0100) begin
      errors++;
      $display("FAIL mid_next: got lat=%0d d=%b want 3 0100", lat, res_data);
    end
    ack();
  endtask

`ifdef ALSU_SHIFT_STICKY_EN
  task automatic test_sticky();
    int lat, sh;
    logic [3:0] fa, fb;
    logic [1:0] fs;
    logic any;
    issue(4'b0101, 4'b0000, 2'b00, 3'd2);
    wait_done(lat, sh, fa, fb, fs, any);
    checks++;
    if (res_data !== 4'b0001 || res_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky: got d=%b s=%b want 0001 1", res_data, res_sticky);
    end
    ack();
  endtask
`endif

  initial begin
    test_reset();
    test_shr_a();
    test_shl_b();
    test_zero_amt();
    test_clamp();
    test_backpressure();
    test_reset_mid_shift();
`ifdef ALSU_SHIFT_STICKY_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
